// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a one-entry skid buffer on the output.
// Decodes format, immediate and legality, and counts illegal inputs.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    F_NONE = 3'd0,
    F_I    = 3'd1,
    F_S    = 3'd2,
    F_B    = 3'd3,
    F_U    = 3'd4,
    F_J    = 3'd5,
    F_Z    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_i, is_s, is_b, is_u;
  logic        is_j, is_sys, is_nop;
  logic [63:0] w;
  ent_t        d;
  ent_t        o_q, o_n;
  ent_t        s_q, s_n;
  logic        ov_q, ov_n;
  logic        sv_q, sv_n;
  logic        rdy_q;
  logic [CNT_W-1:0] cnt_q;
  logic        acc, xfer;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];

  assign is_i = (opc == 7'b0010011) ||
                (opc == 7'b0000011) ||
                (opc == 7'b1100111) ||
                (RV64 && opc == 7'b0011011);
  assign is_s = (opc == 7'b0100011);
  assign is_b = (opc == 7'b1100011);
  assign is_u = (opc == 7'b0110111) ||
                (opc == 7'b0010111);
  assign is_j = (opc == 7'b1101111);
  assign is_sys = (opc == 7'b1110011);
  assign is_nop = (opc == 7'b0110011) ||
                  (opc == 7'b0001111) ||
                  (RV64 && opc == 7'b0111011);

  // Decode format and build a 64-bit sign-extended immediate.
  always_comb begin
    w = '0;
    d = '0;
    unique case (1'b1)
      is_i: begin
        d.fmt = F_I;
        w = {{52{in_instr[31]}}, in_instr[31:20]};
      end
      is_s: begin
        d.fmt = F_S;
        w = {{52{in_instr[31]}}, in_instr[31:25],
             in_instr[11:7]};
      end
      is_b: begin
        d.fmt = F_B;
        w = {{51{in_instr[31]}}, in_instr[31],
             in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
      end
      is_u: begin
        d.fmt = F_U;
        w = {{32{in_instr[31]}}, in_instr[31:12],
             12'b0};
      end
      is_j: begin
        d.fmt = F_J;
        w = {{43{in_instr[31]}}, in_instr[31],
             in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};
      end
      is_sys: begin
        if (f3[2]) begin
          d.fmt = F_Z;
          w = {59'b0, in_instr[19:15]};
        end
      end
      is_nop: begin
        d.fmt = F_NONE;
      end
      default: begin
        d.ill = 1'b1;
      end
    endcase
    if (!RV64 && opc == 7'b0010011 &&
        f3[1:0] == 2'b01 && in_instr[25])
      d.ill = 1'b1;
    d.imm = w[XLEN-1:0];
  end

  assign acc  = in_valid && rdy_q;
  assign xfer = ov_q && out_ready;

  // Output register / skid entry steering.
  always_comb begin
    ov_n = ov_q;
    sv_n = sv_q;
    o_n  = o_q;
    s_n  = s_q;
    if (sv_q) begin
      if (xfer) begin
        o_n  = s_q;
        sv_n = 1'b0;
      end
    end else if (acc) begin
      if (!ov_q || out_ready) begin
        o_n  = d;
        ov_n = 1'b1;
      end else begin
        s_n  = d;
        sv_n = 1'b1;
      end
    end else if (xfer) begin
      ov_n = 1'b0;
    end
  end

  // State registers; in_ready is registered off the next skid state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q  <= 1'b0;
      sv_q  <= 1'b0;
      rdy_q <= 1'b0;
      o_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      ov_q  <= ov_n;
      sv_q  <= sv_n;
      rdy_q <= !sv_n;
      o_q   <= o_n;
      s_q   <= s_n;
      if (acc && d.ill && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = ov_q;
  assign imm_out     = o_q.imm;
  assign fmt_out     = o_q.fmt;
  assign illegal_out = o_q.ill;
  assign err_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe, XLEN=32 and XLEN=64 side by side.
// Random and directed stimulus checked against a reference decoder.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    int          cyc;
  } exp_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0;
  logic [31:0] in_instr = 0;
  logic        out_ready = 0;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  cnt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  cnt64;

  exp_t q32[$];
  exp_t q64[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   nvec = 0;
  int   cyc = 0;
  int   e32 = 0;
  int   e64 = 0;
  bit   lat_chk = 0;
  bit   h32 = 0;
  bit   h64 = 0;
  logic [63:0] pi32, pi64;
  logic [3:0]  pf32, pf64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr),
    .out_valid(ov32), .out_ready(out_ready),
    .imm_out(imm32), .fmt_out(fmt32),
    .illegal_out(ill32), .err_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr),
    .out_valid(ov64), .out_ready(out_ready),
    .imm_out(imm64), .fmt_out(fmt64),
    .illegal_out(ill64), .err_cnt(cnt64)
  );

  function automatic void check(string nm,
                                logic [63:0] a,
                                logic [63:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endfunction

  // Reference decoder written from the ISA immediate rules.
  function automatic exp_t model(logic [31:0] i, int xl);
    exp_t r;
    longint v;
    bit rv64;
    logic signed [11:0] ti;
    logic signed [11:0] ts;
    logic signed [11:0] tb;
    logic signed [19:0] tu;
    logic signed [19:0] tj;
    rv64 = (xl == 64);
    r.fmt = 0;
    r.ill = 0;
    r.cyc = 0;
    v = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: r.fmt = 1;
      7'h1B: if (rv64) r.fmt = 1; else r.ill = 1;
      7'h23: r.fmt = 2;
      7'h63: r.fmt = 3;
      7'h37, 7'h17: r.fmt = 4;
      7'h6F: r.fmt = 5;
      7'h73: if (i[14]) r.fmt = 6;
      7'h33, 7'h0F: r.fmt = 0;
      7'h3B: if (!rv64) r.ill = 1;
      default: r.ill = 1;
    endcase
    ti = i[31:20];
    ts = {i[31:25], i[11:7]};
    tb = {i[31], i[7], i[30:25], i[11:8]};
    tu = i[31:12];
    tj = {i[31], i[19:12], i[20], i[30:21]};
    case (r.fmt)
      1: v = ti;
      2: v = ts;
      3: v = 2 * longint'(tb);
      4: v = 4096 * longint'(tu);
      5: v = 2 * longint'(tj);
      6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    if (!rv64 && i[6:0] == 7'h13 &&
        i[13:12] == 2'b01 && i[25])
      r.ill = 1;
    r.imm = rv64 ? v : {32'b0, v[31:0]};
    return r;
  endfunction

  // Monitor: compare outputs on transfer, then log accepts.
  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (reset) begin
      q32.delete();
      q64.delete();
      e32 = 0;
      e64 = 0;
      h32 = 0;
      h64 = 0;
    end else begin
      check("errcnt32", 64'(cnt32), 64'(e32));
      check("errcnt64", 64'(cnt64), 64'(e64));
      if (h32) begin
        check("hold_imm32", 64'(imm32), pi32);
        check("hold_fi32", 64'({fmt32, ill32}), 64'(pf32));
      end
      if (h64) begin
        check("hold_imm64", imm64, pi64);
        check("hold_fi64", 64'({fmt64, ill64}), 64'(pf64));
      end
      h32 = ov32 && !out_ready;
      h64 = ov64 && !out_ready;
      pi32 = 64'(imm32);
      pf32 = {fmt32, ill32};
      pi64 = imm64;
      pf64 = {fmt64, ill64};
      if (ov32 && out_ready) begin
        if (q32.size() == 0) begin
          check("pop32_empty", 64'(1), 64'(0));
        end else begin
          x = q32.pop_front();
          check("imm32", 64'(imm32), x.imm);
          check("fmt32", 64'(fmt32), 64'(x.fmt));
          check("ill32", 64'(ill32), 64'(x.ill));
          if (lat_chk)
            check("lat32", 64'(cyc - x.cyc), 64'(1));
        end
      end
      if (ov64 && out_ready) begin
        if (q64.size() == 0) begin
          check("pop64_empty", 64'(1), 64'(0));
        end else begin
          x = q64.pop_front();
          check("imm64", imm64, x.imm);
          check("fmt64", 64'(fmt64), 64'(x.fmt));
          check("ill64", 64'(ill64), 64'(x.ill));
          if (lat_chk)
            check("lat64", 64'(cyc - x.cyc), 64'(1));
        end
      end
      if (in_valid && rdy32) begin
        x = model(in_instr, 32);
        x.cyc = cyc;
        q32.push_back(x);
        nvec++;
        if (x.ill) e32 = (e32 == 255) ? 255 : e32 + 1;
      end
      if (in_valid && rdy64) begin
        x = model(in_instr, 64);
        x.cyc = cyc;
        q64.push_back(x);
        if (x.ill) e64 = (e64 == 255) ? 255 : e64 + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    int n;
    in_valid = 1;
    in_instr = ins;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rdy32) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 64'(1), 64'(0));
        break;
      end
    end
    tick();
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    repeat (5) tick();
    check("drain32", 64'(q32.size()), 64'(0));
    check("drain64", 64'(q64.size()), 64'(0));
  endtask

  logic [6:0] ops [14] = '{
    7'h13, 7'h03, 7'h67, 7'h1B, 7'h23,
    7'h63, 7'h37, 7'h17, 7'h6F, 7'h73,
    7'h33, 7'h0F, 7'h3B, 7'h00
  };

  initial begin
    int base;
    logic [31:0] r;
    reset = 1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_ov", 64'(ov32), 64'(0));
    check("rst_rdy", 64'(rdy32), 64'(0));
    check("rst_imm", 64'(imm32), 64'(0));
    check("rst_fi", 64'({fmt32, ill32}), 64'(0));
    check("rst_cnt", 64'(cnt32), 64'(0));
    tick();
    reset = 0;
    tick();
    @(negedge clk);
    check("rdy_after_rst", 64'(rdy32), 64'(1));
    tick();

    out_ready = 1;
    lat_chk = 1;
    send(32'hFFF00093);
    send(32'hFE20AE23);
    send(32'h800002B7);
    send(32'h300FD073);
    drain();
    base = int'(cnt32);
    send(32'h0000001B);
    send(32'h02009093);
    drain();
    check("cnt_plus2", 64'(cnt32), 64'(base + 2));

    lat_chk = 0;
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'h00100093;
    tick();
    in_instr = 32'h00200093;
    tick();
    in_instr = 32'h00300093;
    @(negedge clk);
    check("skid_full_rdy", 64'(rdy32), 64'(0));
    tick();
    @(negedge clk);
    check("skid_hold_rdy", 64'(rdy32), 64'(0));
    tick();
    out_ready = 1;
    send(32'h00300093);
    drain();

    out_ready = 0;
    in_valid = 1;
    in_instr = 32'h00000000;
    tick();
    tick();
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    check("mid_rst_ov", 64'(ov32), 64'(0));
    check("mid_rst_cnt", 64'(cnt32), 64'(0));
    check("mid_rst_rdy0", 64'(rdy32), 64'(0));
    tick();
    @(negedge clk);
    check("mid_rst_rdy1", 64'(rdy32), 64'(1));
    tick();

    for (int k = 0; k < 500; k++) begin
      out_ready = ($urandom % 4) != 0;
      in_valid = ($urandom % 3) != 0;
      r = $urandom;
      if (($urandom % 8) != 0)
        r[6:0] = ops[$urandom % 14];
      in_instr = r;
      tick();
    end
    drain();

    lat_chk = 1;
    for (int k = 0; k < 300; k++)
      send(32'h00000000);
    drain();
    check("sat32", 64'(cnt32), 64'(255));
    check("sat64", 64'(cnt64), 64'(255));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1, "timeout");
  end

endmodule
